shared_adder_arb: RTL and testbench

Round-robin arbiter that time-shares one pipelined WIDTH-bit adder among NREQ requesters. Each requester issues operand pairs over a valid/ready handshake. The block grants at most one request per cycle, carries the requester ID down the pipeline, and returns the sum to the originator LAT cycles later. It sits between compute clients and the single shared adder datapath so that one adder instance serves all of them.

---
 rtl/shared_adder_arb_if.sv | 27 ++
 rtl/shared_adder_arb.sv | 154 +++++++++++++++
 tb/tb_shared_adder_arb.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_adder_arb_if.sv
// Requester-side bus of the shared adder arbiter: request handshake with
// packed operands, plus the response strobe, sum and requester id.
interface shared_adder_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_sum;
  logic [IDW-1:0]        rsp_id;

  // Requesters drive operands and consume grants/responses.
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  // The arbiter consumes operands and drives grants/responses.
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/shared_adder_arb.sv
// Round-robin arbiter in front of one pipelined adder. At most one request
// is granted per cycle; the requester id travels with the operation and the
// sum comes back to that requester LAT cycles after the transfer.
module shared_adder_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  shared_adder_arb_if.slave   bus,
  output logic                busy,
  output logic [15:0]         op_count
);

  // Arbitration state and grant decode
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             xfer;
  logic [NREQ-1:0]  ready_w;

  // Operand selection and adder result entering stage 1
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_d;

  // Pipeline valid bits; vld_q[LAT] flags the response stage
  logic [LAT:1]     vld_q;

  // Values presented to the final (response) stage on the next edge
  logic             fin_vld_d;
  logic [IDW-1:0]   fin_id_d;
  logic [WIDTH-1:0] fin_sum_d;

  // Registered response and operation counter
  logic [WIDTH-1:0] rsp_sum_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [15:0]      op_cnt_q;
  logic [NREQ-1:0]  rsp_valid_w;

  // Rotating priority search: first valid port at or above ptr, else the
  // first valid port below ptr. This is the modulo walk ptr, ptr+1, ...
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && bus.req_valid[i] && (IDW'(i) >= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && bus.req_valid[i] && (IDW'(i) < ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
  end

  // Grant is suppressed entirely while enable is low; the pointer then holds.
  always_comb begin
    xfer    = enable && gnt_found;
    ready_w = xfer ? (NREQ'(1) << gnt_idx) : '0;
    ptr_d   = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // Select the granted operands and add them; the carry-out is dropped.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op_a = bus.req_a[i*WIDTH +: WIDTH];
        op_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
    sum_d = op_a + op_b;
  end

  // ---- stage 1 .. LAT-1: forward id and sum toward the response stage ----
  generate
    if (LAT > 1) begin : g_mid
      logic [IDW-1:0]   id_q  [1:LAT-1];
      logic [WIDTH-1:0] sum_q [1:LAT-1];

      // Data-only shift register; validity is tracked separately in vld_q.
      always_ff @(posedge clk) begin
        id_q[1]  <= gnt_idx;
        sum_q[1] <= sum_d;
        for (int s = 2; s < LAT; s++) begin
          id_q[s]  <= id_q[s-1];
          sum_q[s] <= sum_q[s-1];
        end
      end

      assign fin_vld_d = vld_q[LAT-1];
      assign fin_id_d  = id_q[LAT-1];
      assign fin_sum_d = sum_q[LAT-1];
    end else begin : g_direct
      assign fin_vld_d = xfer;
      assign fin_id_d  = gnt_idx;
      assign fin_sum_d = sum_d;
    end
  endgenerate

  // Control state: pointer, stage valid bits and accepted-op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      vld_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      vld_q[1] <= xfer;
      for (int s = 2; s <= LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      if (xfer) begin
        op_cnt_q <= op_cnt_q + 16'd1;
      end
    end
  end

  // ---- stage LAT: response register, holds its value between responses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum_q <= '0;
      rsp_id_q  <= '0;
    end else if (fin_vld_d) begin
      rsp_sum_q <= fin_sum_d;
      rsp_id_q  <= fin_id_d;
    end
  end

  // One-hot response strobe decoded from the registered final stage.
  always_comb begin
    rsp_valid_w = vld_q[LAT] ? (NREQ'(1) << rsp_id_q) : '0;
  end

  assign bus.req_ready = ready_w;
  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = |vld_q;
  assign op_count      = op_cnt_q;

endmodule

// File: tb/tb_shared_adder_arb.sv
// Bench for shared_adder_arb: table-driven arbitration vectors, hand-written
// corner sequences and a randomized phase, all checked against a queue-based
// reference model of the arbiter and adder pipeline.
module tb_shared_adder_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int LAT   = 2;
  localparam int IDW   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic [15:0] op_count;

  shared_adder_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  shared_adder_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int          due;
    int          id;
    logic [31:0] sum;
  } rsp_t;

  rsp_t        pq[$];
  int          ptr_m;
  int          cyc;
  logic [15:0] cnt_m;
  logic [31:0] last_sum;
  int          last_id;
  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];

  int n_chk;
  int n_fail;

  typedef struct {
    logic [NREQ-1:0] v;
    logic            en;
    logic [NREQ-1:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    ptr_m    = 0;
    cnt_m    = '0;
    last_sum = '0;
    last_id  = 0;
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input logic en);
    if (!en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr_m + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, check once settled, then
  // advance the model by the transfer (if any) taken on the next rising edge.
  task automatic step(input logic [NREQ-1:0] v, input logic en, output int g);
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rv;
    bit              delivered;
    rsp_t            r;
    @(negedge clk);
    enable        = en;
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
      bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
    #1;
    g = model_grant(v, en);
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", bus.req_ready, exp_rdy);
    delivered = 0;
    exp_rv    = '0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_rv    = NREQ'(1) << pq[0].id;
      last_sum  = pq[0].sum;
      last_id   = pq[0].id;
      delivered = 1;
      void'(pq.pop_front());
    end
    chk("rsp_valid", bus.rsp_valid, exp_rv);
    chk("rsp_sum", bus.rsp_sum, last_sum);
    chk("rsp_id", bus.rsp_id, last_id);
    chk("busy", busy, (delivered || pq.size() > 0) ? 1 : 0);
    chk("op_count", op_count, cnt_m);
    if (g >= 0) begin
      r.due = cyc + LAT;
      r.id  = g;
      r.sum = op_a[g] + op_b[g];
      pq.push_back(r);
      cnt_m++;
      ptr_m   = (g + 1) % NREQ;
      op_a[g] = rnd_op();
      op_b[g] = rnd_op();
    end
    cyc++;
  endtask

  initial begin
    int              g;
    logic [NREQ-1:0] pend;
    int              waitc [NREQ];

    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = $urandom;
      op_b[i]  = $urandom;
      waitc[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Arbitration vectors applied consecutively from a reset pointer of 0.
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0100};  // ptr -> 3
    tbl[2]  = '{4'b1010, 1'b1, 4'b1000};  // ptr 3, ports 1 and 3: 3 first
    tbl[3]  = '{4'b0010, 1'b1, 4'b0010};  // then 1, ptr -> 2
    tbl[4]  = '{4'b1111, 1'b0, 4'b0000};  // enable low x3
    tbl[5]  = '{4'b1111, 1'b0, 4'b0000};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0100};  // resumes at held ptr 2
    tbl[8]  = '{4'b1111, 1'b1, 4'b1000};  // port 2 re-asserts, goes last
    tbl[9]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[10] = '{4'b1111, 1'b1, 4'b0010};
    tbl[11] = '{4'b1111, 1'b1, 4'b0100};
    tbl[12] = '{4'b1011, 1'b1, 4'b1000};
    tbl[13] = '{4'b0011, 1'b1, 4'b0001};
    tbl[14] = '{4'b0010, 1'b1, 4'b0010};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000};

    // Reset state
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_sum", bus.rsp_sum, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    rst_n = 1'b1;

    // Single op: port 2, 5 + 7
    op_a[2] = 32'd5;
    op_b[2] = 32'd7;
    step(4'b0100, 1'b1, g);
    chk("single_ready", bus.req_ready, 4'b0100);
    step(4'b0000, 1'b1, g);
    chk("single_busy_t1", busy, 1);
    step(4'b0000, 1'b1, g);
    chk("single_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("single_rsp_sum", bus.rsp_sum, 12);
    chk("single_rsp_id", bus.rsp_id, 2);
    chk("single_busy_t2", busy, 1);
    step(4'b0000, 1'b1, g);
    chk("single_busy_t3", busy, 0);
    chk("single_sum_hold", bus.rsp_sum, 12);

    // Wrap-around sum on port 1
    op_a[1] = 32'hFFFF_FFFF;
    op_b[1] = 32'h0000_0002;
    step(4'b0010, 1'b1, g);
    step(4'b0000, 1'b1, g);
    step(4'b0000, 1'b1, g);
    chk("wrap_rsp_sum", bus.rsp_sum, 32'h0000_0001);
    chk("wrap_rsp_valid", bus.rsp_valid, 4'b0010);

    // Reset one cycle after a transfer (pointer left at 3 by this grant)
    step(4'b0100, 1'b1, g);
    @(negedge clk);
    bus.req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_rsp_sum", bus.rsp_sum, 0);
    #1 rst_n = 1'b1;
    model_reset();
    cyc++;

    // Fairness from reset: all ports continuously valid
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b1, g);
      chk("fair_order", bus.req_ready, NREQ'(1) << (k % NREQ));
    end
    step(4'b1111, 1'b1, g);
    chk("fair_op_count", op_count, 8);
    step(4'b1110, 1'b1, g);
    step(4'b1100, 1'b1, g);
    step(4'b1000, 1'b1, g);

    // Table-driven arbitration sequence (pointer is back at 0 here)
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].v, tbl[k].en, g);
      chk("tbl_ready", bus.req_ready, tbl[k].exp);
    end

    // Randomized traffic with requesters holding requests until transfer
    pend = '0;
    for (int c = 0; c < 1500; c++) begin
      logic en;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op_a[i] = rnd_op();
          op_b[i] = rnd_op();
        end
      end
      en = ($urandom_range(0, 7) != 0);
      step(pend, en, g);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && en) begin
          if (g == i) begin
            n_chk++;
            if (waitc[i] > NREQ - 1) begin
              n_fail++;
              $display("FAIL max_wait port %0d: waited %0d cycles, limit %0d", i, waitc[i], NREQ - 1);
            end
            waitc[i] = 0;
          end else begin
            waitc[i]++;
          end
        end
      end
      if (g >= 0) pend[g] = 1'b0;
    end

    // Drain with requests still held but no new grants
    for (int k = 0; k < LAT + 2; k++) begin
      step(pend, 1'b0, g);
    end
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
